// File: rtl/cp0_exc_ctrl_pkg.sv
// CP0 shared definitions: register numbers, Status/Cause field positions
// and the architectural ExcCode values.
package cp0_exc_ctrl_pkg;

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;
    localparam logic [4:0] REG_PRID     = 5'd15;
    localparam logic [4:0] REG_CONFIG   = 5'd16;

    localparam int ST_IE     = 0;
    localparam int ST_EXL    = 1;
    localparam int ST_IM_LO  = 8;
    localparam int ST_IM_HI  = 15;
    localparam int CA_IP_LO  = 8;
    localparam int CA_IP_HI  = 15;
    localparam int CA_BD     = 31;
    localparam int CA_EXC_LO = 2;
    localparam int CA_EXC_HI = 6;

    // IV, WP and the two software interrupt bits
    localparam logic [31:0] CAUSE_WMASK = 32'h00C0_0300;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_SYS  = 5'd8,
        EXC_OV   = 5'd12
    } exc_code_e;

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer: prescaler, Count, Compare and the sticky
// timer-interrupt flag.
module cp0_timer
    import cp0_exc_ctrl_pkg::*;
#(
    parameter int COUNT_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        timer_int_o
);

    logic        presc_q, presc_d;
    logic        tick;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        timer_q, timer_d;
    logic        wr_count, wr_compare;

    assign wr_count   = we_i && (waddr_i == REG_COUNT);
    assign wr_compare = we_i && (waddr_i == REG_COMPARE);

    always_comb begin
        presc_d = 1'b0;
        tick    = 1'b1;
        if (COUNT_DIV == 2) begin
            presc_d = ~presc_q;
            tick    = presc_q;
        end

        count_d = tick ? count_q + 32'd1 : count_q;
        if (wr_count) count_d = wdata_i;

        compare_d = compare_q;
        if (wr_compare) compare_d = wdata_i;

        // A Compare write acknowledges the interrupt and beats a new match
        timer_d = timer_q | ((compare_q != 32'd0) && (count_q == compare_q));
        if (wr_compare) timer_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q   <= 1'b0;
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            timer_q   <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            timer_q   <= timer_d;
        end
    end

    assign count_o     = count_q;
    assign compare_o   = compare_q;
    assign timer_int_o = timer_q;

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 register file with exception entry, ERET, BadVAddr capture,
// interrupt request generation and read-after-write bypass.
module cp0_exc_ctrl
    import cp0_exc_ctrl_pkg::*;
#(
    parameter int          HW_INT_N   = 6,
    parameter int          TIMER_IP   = 7,
    parameter int          COUNT_DIV  = 1,
    parameter logic [31:0] PRID_VAL   = 32'h004C_0102,
    parameter logic [31:0] CONFIG_VAL = 32'h0000_8000,
    parameter logic [31:0] STATUS_RST = 32'h1000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we_i,
    input  logic [4:0]          waddr_i,
    input  logic [4:0]          raddr_i,
    input  logic [31:0]         wdata_i,
    input  logic [HW_INT_N-1:0] int_i,
    input  logic                exc_valid_i,
    input  logic [4:0]          exc_code_i,
    input  logic [31:0]         exc_pc_i,
    input  logic                exc_bd_i,
    input  logic [31:0]         exc_badva_i,
    input  logic                exc_badva_we_i,
    input  logic                eret_i,
    output logic [31:0]         data_o,
    output logic [31:0]         status_o,
    output logic [31:0]         cause_o,
    output logic [31:0]         epc_o,
    output logic                int_req_o,
    output logic                timer_int_o
);

    logic [31:0] status_q, status_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badva_q, badva_d;
    logic [31:0] count, compare;
    logic        timer_int;
    logic [5:0]  ip_hw;
    logic        exl;
    logic        wr_hit;
    logic [31:0] rdata;

    cp0_timer #(
        .COUNT_DIV (COUNT_DIV)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .we_i        (we_i),
        .waddr_i     (waddr_i),
        .wdata_i     (wdata_i),
        .count_o     (count),
        .compare_o   (compare),
        .timer_int_o (timer_int)
    );

    assign exl = status_q[ST_EXL];

    always_comb begin
        ip_hw = '0;
        ip_hw[HW_INT_N-1:0] = int_i;
        ip_hw[TIMER_IP-2] = ip_hw[TIMER_IP-2] | timer_int;
    end

    // MTC0 first, then ERET, then exception: later writes win per field
    always_comb begin
        status_d = status_q;
        cause_d  = cause_q;
        epc_d    = epc_q;
        badva_d  = badva_q;

        if (we_i) begin
            unique case (waddr_i)
                REG_STATUS: status_d = wdata_i;
                REG_CAUSE:  cause_d  = (cause_q & ~CAUSE_WMASK)
                                     | (wdata_i & CAUSE_WMASK);
                REG_EPC:    epc_d    = wdata_i;
                default:    ;
            endcase
        end

        cause_d[CA_IP_HI:CA_IP_LO+2] = ip_hw;

        if (eret_i && !exc_valid_i) status_d[ST_EXL] = 1'b0;

        if (exc_valid_i) begin
            cause_d[CA_EXC_HI:CA_EXC_LO] = exc_code_i;
            if (!exl) begin
                epc_d = exc_bd_i ? exc_pc_i - 32'd4 : exc_pc_i;
                cause_d[CA_BD] = exc_bd_i;
            end
            status_d[ST_EXL] = 1'b1;
            if (exc_badva_we_i) badva_d = exc_badva_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q <= STATUS_RST;
            cause_q  <= 32'd0;
            epc_q    <= 32'd0;
            badva_q  <= 32'd0;
        end else begin
            status_q <= status_d;
            cause_q  <= cause_d;
            epc_q    <= epc_d;
            badva_q  <= badva_d;
        end
    end

    assign wr_hit = we_i && (waddr_i == raddr_i);

    always_comb begin
        rdata = 32'd0;
        unique case (raddr_i)
            REG_BADVADDR: rdata = badva_q;
            REG_COUNT:    rdata = wr_hit ? wdata_i : count;
            REG_COMPARE:  rdata = wr_hit ? wdata_i : compare;
            REG_STATUS:   rdata = wr_hit ? wdata_i : status_q;
            REG_CAUSE:    rdata = wr_hit ? (cause_q & ~CAUSE_WMASK)
                                         | (wdata_i & CAUSE_WMASK)
                                         : cause_q;
            REG_EPC:      rdata = wr_hit ? wdata_i : epc_q;
            REG_PRID:     rdata = PRID_VAL;
            REG_CONFIG:   rdata = CONFIG_VAL;
            default:      rdata = 32'd0;
        endcase
    end

    assign data_o      = rst ? 32'd0 : rdata;
    assign status_o    = status_q;
    assign cause_o     = cause_q;
    assign epc_o       = epc_q;
    assign timer_int_o = timer_int;
    assign int_req_o   = status_q[ST_IE] & ~exl
                       & |(cause_q[CA_IP_HI:CA_IP_LO]
                           & status_q[ST_IM_HI:ST_IM_LO]);

endmodule
